// File: rtl/codec_pkg.sv
// Shared matrix-codec definitions: slice geometry, controller states and the
// forward/inverse 5x5 lane permutations used by encoder, decoder and benches.
package codec_pkg;

  localparam int unsigned SLICE_W = 25;
  localparam int unsigned SLICES  = 64;
  localparam int unsigned CNT_W   = 6;

  typedef logic [SLICE_W-1:0] slice_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    XFORM = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Reduce a small value (0..14) modulo 5 without a divider.
  function automatic logic [3:0] mod5(input logic [3:0] v);
    logic [3:0] r;
    if (v >= 4'd10)     r = v - 4'd10;
    else if (v >= 4'd5) r = v - 4'd5;
    else                r = v;
    return r;
  endfunction

  // m[5y+x] = s[5*((2x+3y) mod 5) + y]
  function automatic slice_t inv_pi(input slice_t s);
    slice_t     m;
    logic [3:0] a;
    m = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        a = mod5(mod5(4'(2 * x)) + mod5(4'(3 * y)));
        m[5*y+x] = s[5*int'(a)+y];
      end
    end
    return m;
  endfunction

  // s[5a+b] = m[5b + (3a+b) mod 5]; exact inverse of inv_pi.
  function automatic slice_t fwd_pi(input slice_t m);
    slice_t     s;
    logic [3:0] c;
    s = '0;
    for (int a = 0; a < 5; a++) begin
      for (int b = 0; b < 5; b++) begin
        c = mod5(mod5(4'(3 * a)) + 4'(b));
        s[5*a+b] = m[5*b+int'(c)];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/inv_permutation_func_if.sv
// Streaming slice bus between the slice reader, the inverse permutation stage and
// the slice writer, plus frame control and status.
interface inv_permutation_func_if;
  import codec_pkg::*;

  logic                 start;
  logic                 s_valid;
  logic                 s_ready;
  slice_t               s_data;
  logic                 m_valid;
  logic                 m_ready;
  slice_t               m_data;
  logic                 m_last;
  logic [CNT_W-1:0]     slice_idx;
  logic                 busy;
  logic                 done;

  modport slave (
    input  start, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, slice_idx, busy, done
  );

  modport master (
    output start, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, slice_idx, busy, done
  );

endinterface

// File: rtl/inv_permutation_func_inv_pi_slice.sv
// Pure wiring of the inverse lane permutation for one slice.
module inv_pi_slice
  import codec_pkg::*;
(
  input  slice_t d,
  output slice_t q_c
);

  assign q_c = inv_pi(d);

endmodule

// File: rtl/inv_permutation_func.sv
// Decoder-side inverse slice permutation: receives one slice, un-permutes it,
// hands it off, and repeats for a full 64-slice frame.
module inv_permutation_func
  import codec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  inv_permutation_func_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SLICES - 1);

  state_t           state, state_nx;
  slice_t           in_reg, out_reg, xform_c;
  logic [CNT_W-1:0] idx, idx_nx;
  logic             capture, load_out;
  logic             s_ready_q, m_valid_q, m_last_q, busy_q, done_q;

  inv_pi_slice u_inv_pi (
    .d   (in_reg),
    .q_c (xform_c)
  );

  // Next-state and datapath enables.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    capture  = 1'b0;
    load_out = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = RECV;
      end
      RECV: begin
        if (bus.s_valid) begin
          capture  = 1'b1;
          state_nx = XFORM;
        end
      end
      XFORM: begin
        load_out = 1'b1;
        state_nx = SEND;
      end
      SEND: begin
        if (bus.m_ready) begin
          if (idx == LAST_IDX) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = RECV;
          end
        end
      end
      DONE: begin
        idx_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      s_ready_q <= (state_nx == RECV);
      m_valid_q <= (state_nx == SEND);
      m_last_q  <= (state_nx == SEND) && (idx_nx == LAST_IDX);
      busy_q    <= (state_nx != IDLE);
      done_q    <= (state_nx == DONE);
    end
  end

  // Slice holding registers; out_reg stays put while SEND is backpressured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_reg  <= '0;
      out_reg <= '0;
    end else begin
      if (capture)  in_reg  <= bus.s_data;
      if (load_out) out_reg <= xform_c;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = out_reg;
  assign bus.m_last    = m_last_q;
  assign bus.slice_idx = idx;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
